// File: rtl/m_keyscan_pkg.sv
// m_keyscan_pkg: widths, bit-index helper and parameter defaults
// shared by the matrix key scanner files.
package m_keyscan_pkg;

  localparam int KS_ROWS     = 4;
  localparam int KS_COLS     = 4;
  localparam int KS_SETTLE   = 1;
  localparam int KS_DEBOUNCE = 3;

  function automatic int ks_cw(input int rows, input int cols);
    return $clog2(rows * cols);
  endfunction

  // Register width able to hold 0..maxv, never narrower than one bit.
  function automatic int ks_bits(input int maxv);
    return (maxv < 1) ? 1 : $clog2(maxv + 1);
  endfunction

  function automatic int ks_idx(input int r, input int c, input int cols);
    return r * cols + c;
  endfunction

endpackage

// File: rtl/m_lowest_set.sv
// m_lowest_set: priority encoder returning the index of the lowest
// set bit of a mask plus an any-bit-set flag.
module m_lowest_set #(
  parameter int W  = 16,
  parameter int IW = $clog2(W)
) (
  input  logic [W-1:0]  i_mask,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        o_idx = IW'(i);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/m_matrix_scan_ev.sv
// m_matrix_scan_ev: active-low key matrix scanner, frame debounce and
// press/release events; define GHOST_REJECT_EN to reject ghosted frames.
module m_matrix_scan_ev
  import m_keyscan_pkg::*;
#(
  parameter int ROWS     = KS_ROWS,
  parameter int COLS     = KS_COLS,
  parameter int SETTLE   = KS_SETTLE,
  parameter int DEBOUNCE = KS_DEBOUNCE,
  localparam int N       = ROWS * COLS,
  localparam int CW      = ks_cw(ROWS, COLS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ROWS-1:0] row,
  output logic [COLS-1:0] col,
  output logic [N-1:0]    key,
  output logic            tc,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [CW-1:0]   ev_code,
  output logic            ev_press,
  output logic            ghost
);

  localparam int PW = ks_bits(SETTLE);
  localparam int XW = ks_bits(COLS - 1);
  localparam int DW = ks_bits(DEBOUNCE - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(SETTLE);
  localparam logic [XW-1:0] COL_LAST = XW'(COLS - 1);
  localparam logic [DW-1:0] CNT_MAX  = DW'(DEBOUNCE - 1);
  localparam logic [N-1:0]  ONE      = N'(1);

  logic [PW-1:0] r_ph;
  logic [XW-1:0] r_col;
  logic [N-1:0]  r_raw;
  logic [N-1:0]  r_last;
  logic [N-1:0]  r_key;
  logic [N-1:0]  r_pend;
  logic [DW-1:0] r_cnt;
  logic          r_fe;
  logic          r_ghost;

  logic          w_smp;
  logic          w_tc;
  logic          w_same;
  logic          w_ghost;
  logic          w_acc;
  logic          w_any;
  logic          w_hs;
  logic [N-1:0]  w_raw_n;
  logic [N-1:0]  w_pend_c;
  logic [DW-1:0] w_cnt_n;
  logic [CW-1:0] w_code;

  assign w_smp = (r_ph == PH_LAST);
  assign w_tc  = w_smp && (r_col == COL_LAST);
  assign tc    = w_tc;
  assign col   = rst ? '1 : ~(COLS'(1) << r_col);

  always_comb begin
    w_raw_n = r_raw;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (r_col == XW'(c)) w_raw_n[ks_idx(r, c, COLS)] = ~row[r];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ph  <= '0;
      r_col <= '0;
      r_raw <= '0;
      r_fe  <= 1'b0;
    end else begin
      r_fe <= w_tc;
      if (w_smp) begin
        r_ph  <= '0;
        r_col <= (r_col == COL_LAST) ? '0 : r_col + 1'b1;
        r_raw <= w_raw_n;
      end else begin
        r_ph <= r_ph + 1'b1;
      end
    end
  end

`ifdef GHOST_REJECT_EN
  // Two rows sharing a pressed column while spanning 2+ columns form
  // at least three corners of a rectangle.
  function automatic logic f_ghosted(input logic [N-1:0] f);
    logic g;
    logic sh;
    int   n;
    g = 1'b0;
    for (int a = 0; a < ROWS; a++) begin
      for (int b = a + 1; b < ROWS; b++) begin
        sh = 1'b0;
        n  = 0;
        for (int c = 0; c < COLS; c++) begin
          if (f[ks_idx(a, c, COLS)] && f[ks_idx(b, c, COLS)]) sh = 1'b1;
          if (f[ks_idx(a, c, COLS)] || f[ks_idx(b, c, COLS)]) n = n + 1;
        end
        if (sh && n >= 2) g = 1'b1;
      end
    end
    return g;
  endfunction

  assign w_ghost = r_fe && f_ghosted(r_raw);
`else
  assign w_ghost = 1'b0;
`endif

  assign w_same = (r_raw == r_last);

  always_comb begin
    w_cnt_n = '0;
    if (w_same) w_cnt_n = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    if (w_ghost) w_cnt_n = '0;
  end

  m_lowest_set #(
    .W  (N),
    .IW (CW)
  ) u_lowest (
    .i_mask (r_pend),
    .o_idx  (w_code),
    .o_any  (w_any)
  );

  assign w_hs     = w_any && ev_ready;
  assign w_pend_c = w_hs ? (r_pend & ~(ONE << w_code)) : r_pend;
  // A frame waiting behind undrained events is simply re-tried here.
  assign w_acc = r_fe && !w_ghost && (w_cnt_n == CNT_MAX)
              && (r_raw != r_key) && (w_pend_c == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last  <= '0;
      r_cnt   <= '0;
      r_key   <= '0;
      r_pend  <= '0;
      r_ghost <= 1'b0;
    end else begin
      r_ghost <= w_ghost;
      if (r_fe) begin
        r_cnt <= w_cnt_n;
        if (!w_same) r_last <= r_raw;
      end
      if (w_acc) begin
        r_key  <= r_raw;
        r_pend <= r_raw ^ r_key;
      end else begin
        r_pend <= w_pend_c;
      end
    end
  end

  assign key      = r_key;
  assign ev_valid = w_any;
  assign ev_code  = w_code;
  assign ev_press = r_key[w_code];
  assign ghost    = r_ghost;

endmodule
